bht_update_ctrl: RTL and testbench

- Sequences all writes into the branch history table's single write port (ld_bht / pc_taken_in / taken_in).
- After reset or flush it sweeps every table entry to all-zero history. It then merges up to two branch-resolution updates per cycle through a small FIFO and drains one write per cycle.
- Sits between the branch-resolve/commit logic and the history table.

---
 rtl/bht_update_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bht_update_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: owns the single write port of the branch history table.
// After reset or flush it sweeps every entry to zero history, one shift per
// cycle. It then queues up to two branch-resolution updates per cycle in a
// small FIFO and drains one table write per cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 restart the clearing sweep and drop queued updates
//   req0_*                update request from the older branch (valid/idx/taken/ready)
//   req1_*                update request from the younger branch (valid/idx/taken/ready)
//   ld_bht                table write enable (registered)
//   pc_taken_in           table write index (registered)
//   taken_in              history bit shifted into the entry (registered)
//   init_busy             high while the clearing sweep runs
//   fifo_count            number of queued updates
module bht_update_ctrl #(
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned HIST_W = 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         req0_valid,
  input  logic [IDX_W-1:0]             req0_idx,
  input  logic                         req0_taken,
  output logic                         req0_ready,
  input  logic                         req1_valid,
  input  logic [IDX_W-1:0]             req1_idx,
  input  logic                         req1_taken,
  output logic                         req1_ready,
  output logic                         ld_bht,
  output logic [IDX_W-1:0]             pc_taken_in,
  output logic                         taken_in,
  output logic                         init_busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned REP_W   = (HIST_W > 1) ? $clog2(HIST_W) : 1;
  localparam int unsigned IDX_MAX = (1 << IDX_W) - 1;
  localparam int unsigned ENT_W   = IDX_W + 1;

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx_cnt, idx_next;
  logic [REP_W-1:0]   rep_cnt, rep_next;
  logic [PTR_W-1:0]   wr_ptr, wr_next, rd_ptr, rd_next;
  logic [CNT_W-1:0]   cnt_next, free;
  logic               ld_next, tk_next;
  logic [IDX_W-1:0]   pc_next;
  logic               push0, push1, pop;
  logic               wen0, wen1;
  logic [PTR_W-1:0]   wa1;
  logic [ENT_W-1:0]   wd0, head;

  // Entries are {taken, idx}.
  logic [ENT_W-1:0]   mem [DEPTH];

  assign init_busy = (state == S_INIT);
  assign free      = CNT_W'(DEPTH) - fifo_count;
  assign head      = mem[rd_ptr];
  assign wa1       = wr_ptr + PTR_W'(1);

  // Next-state, handshake and write-port decode.
  always_comb begin
    state_next = state;
    idx_next   = idx_cnt;
    rep_next   = rep_cnt;
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    cnt_next   = fifo_count;
    ld_next    = 1'b0;
    pc_next    = pc_taken_in;
    tk_next    = taken_in;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    push0      = 1'b0;
    push1      = 1'b0;
    pop        = 1'b0;
    wen0       = 1'b0;
    wen1       = 1'b0;
    wd0        = {req0_taken, req0_idx};

    if (flush) begin
      state_next = S_INIT;
      idx_next   = '0;
      rep_next   = '0;
      wr_next    = '0;
      rd_next    = '0;
      cnt_next   = '0;
    end else begin
      case (state)
        S_INIT: begin
          ld_next = 1'b1;
          pc_next = idx_cnt;
          tk_next = 1'b0;
          if (rep_cnt == REP_W'(HIST_W - 1)) begin
            rep_next = '0;
            idx_next = idx_cnt + IDX_W'(1);
            if (idx_cnt == IDX_W'(IDX_MAX)) state_next = S_RUN;
          end else begin
            rep_next = rep_cnt + REP_W'(1);
          end
        end
        S_RUN: begin
          // req1 may take the last slot only if req0 is not competing for it.
          req0_ready = (free >= CNT_W'(1));
          req1_ready = (free >= CNT_W'(2)) || ((free >= CNT_W'(1)) && !req0_valid);
          push0      = req0_valid && req0_ready;
          push1      = req1_valid && req1_ready;
          pop        = (fifo_count != '0);
          // The first accepted request takes wr_ptr; a second goes right behind it.
          wen0       = push0 || push1;
          wen1       = push0 && push1;
          wd0        = push0 ? {req0_taken, req0_idx} : {req1_taken, req1_idx};
          wr_next    = wr_ptr + PTR_W'(push0) + PTR_W'(push1);
          if (pop) begin
            rd_next = rd_ptr + PTR_W'(1);
            ld_next = 1'b1;
            pc_next = head[IDX_W-1:0];
            tk_next = head[IDX_W];
          end
          cnt_next = fifo_count + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);
        end
        default: state_next = S_INIT;
      endcase
    end
  end

  // State, counters and registered table-write outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      idx_cnt     <= '0;
      rep_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      ld_bht      <= 1'b0;
      pc_taken_in <= '0;
      taken_in    <= 1'b0;
    end else begin
      state       <= state_next;
      idx_cnt     <= idx_next;
      rep_cnt     <= rep_next;
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      fifo_count  <= cnt_next;
      ld_bht      <= ld_next;
      pc_taken_in <= pc_next;
      taken_in    <= tk_next;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (wen0) mem[wr_ptr] <= wd0;
    if (wen1) mem[wa1]    <= {req1_taken, req1_idx};
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
module tb_bht_update_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       req0_valid, req0_taken, req0_ready;
  logic [2:0] req0_idx;
  logic       req1_valid, req1_taken, req1_ready;
  logic [2:0] req1_idx;
  logic       ld_bht;
  logic [2:0] pc_taken_in;
  logic       taken_in;
  logic       init_busy;
  logic [2:0] fifo_count;

  int n_tests = 0;
  int n_fail  = 0;

  bht_update_ctrl #(.IDX_W(3), .HIST_W(3), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_taken(req0_taken), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_taken(req1_taken), .req1_ready(req1_ready),
    .ld_bht(ld_bht), .pc_taken_in(pc_taken_in), .taken_in(taken_in),
    .init_busy(init_busy), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  // 24 consecutive clearing writes: idx k/3, taken 0.
  task automatic check_sweep(input string tag);
    for (int k = 0; k < 24; k++) begin
      edge_sample();
      n_tests++;
      if ({ld_bht, pc_taken_in, taken_in} !== {1'b1, 3'(k / 3), 1'b0}) begin
        n_fail++;
        $display("FAIL %s write %0d: got ld=%b idx=%0d tk=%b, want ld=1 idx=%0d tk=0",
                 tag, k, ld_bht, pc_taken_in, taken_in, k / 3);
      end
    end
    edge_sample();
    n_tests++;
    if ({ld_bht, init_busy, req0_ready, req1_ready} !== 4'b0011) begin
      n_fail++;
      $display("FAIL %s after sweep: got ld=%b busy=%b r0=%b r1=%b, want 0 0 1 1",
               tag, ld_bht, init_busy, req0_ready, req1_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0;
    req0_valid = 1'b0; req0_idx = '0; req0_taken = 1'b0;
    req1_valid = 1'b0; req1_idx = '0; req1_taken = 1'b0;
    #23;
    n_tests++;
    if ({ld_bht, pc_taken_in, taken_in, init_busy, req0_ready, req1_ready, fifo_count}
        !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_values: got ld=%b idx=%0d tk=%b busy=%b r0=%b r1=%b cnt=%0d",
               ld_bht, pc_taken_in, taken_in, init_busy, req0_ready, req1_ready, fifo_count);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_idx = 3'd5; req0_taken = 1'b1;
    edge_sample();
    n_tests++;
    if (fifo_count !== 3'd1 || ld_bht !== 1'b0) begin
      n_fail++;
      $display("FAIL single_accept: got cnt=%0d ld=%b, want cnt=1 ld=0", fifo_count, ld_bht);
    end
    @(negedge clk) req0_valid = 1'b0;
    edge_sample();
    n_tests++;
    if ({ld_bht, pc_taken_in, taken_in, fifo_count} !== {1'b1, 3'd5, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL single_write: got ld=%b idx=%0d tk=%b cnt=%0d, want 1 5 1 0",
               ld_bht, pc_taken_in, taken_in, fifo_count);
    end
    edge_sample();
    n_tests++;
    if (ld_bht !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pulse_end: got ld=%b want 0", ld_bht);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_r1;
    logic [2:0] exp_cnt [8];
    logic [7:0] exp_ld;
    logic [2:0] exp_pc  [8];
    logic [7:0] exp_tk;
    exp_r1 = 4'b0011;                     // bit c = cycle c (free 4,2,1,1)
    exp_cnt = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    exp_ld = 8'b0111_1110;                // bit e = edge e+1
    exp_pc = '{3'd0, 3'd2, 3'd6, 3'd2, 3'd6, 3'd2, 3'd2, 3'd0};
    exp_tk = 8'b0110_1010;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      if (e < 4) begin
        req0_valid = 1'b1; req0_idx = 3'd2; req0_taken = 1'b1;
        req1_valid = 1'b1; req1_idx = 3'd6; req1_taken = 1'b0;
        #1;
        n_tests++;
        if (req0_ready !== 1'b1 || req1_ready !== exp_r1[e]) begin
          n_fail++;
          $display("FAIL b2b_ready c%0d: got r0=%b r1=%b, want r0=1 r1=%b",
                   e, req0_ready, req1_ready, exp_r1[e]);
        end
      end else begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      edge_sample();
      n_tests++;
      if (fifo_count !== exp_cnt[e] || ld_bht !== exp_ld[e] ||
          (exp_ld[e] && (pc_taken_in !== exp_pc[e] || taken_in !== exp_tk[e]))) begin
        n_fail++;
        $display("FAIL b2b_edge %0d: got cnt=%0d ld=%b idx=%0d tk=%b, want cnt=%0d ld=%b idx=%0d tk=%b",
                 e + 1, fifo_count, ld_bht, pc_taken_in, taken_in,
                 exp_cnt[e], exp_ld[e], exp_pc[e], exp_tk[e]);
      end
    end
  endtask

  // Two paired pushes leave three entries queued (one already popped).
  task automatic fill_three(input logic [2:0] a, b, c, d);
    @(negedge clk);
    req0_valid = 1'b1; req0_idx = a; req0_taken = 1'b1;
    req1_valid = 1'b1; req1_idx = b; req1_taken = 1'b0;
    @(negedge clk);
    req0_idx = c; req1_idx = d;
    edge_sample();
  endtask

  task automatic test_ready_rules();
    logic [2:0] exp_cnt [5];
    logic [4:0] exp_ld;
    logic [2:0] exp_pc  [5];
    logic [4:0] exp_tk;
    fill_three(3'd1, 3'd3, 3'd4, 3'd7);   // writes 1 then queue 3,4,7
    n_tests++;
    if (fifo_count !== 3'd3 || {ld_bht, pc_taken_in, taken_in} !== {1'b1, 3'd1, 1'b1}) begin
      n_fail++;
      $display("FAIL rr_fill: got cnt=%0d ld=%b idx=%0d tk=%b, want 3 1 1 1",
               fifo_count, ld_bht, pc_taken_in, taken_in);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_idx = 3'd5; req1_taken = 1'b1;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rr_free1_r1alone: got r0=%b r1=%b, want 1 1", req0_ready, req1_ready);
    end
    req0_valid = 1'b1; req0_idx = 3'd0; req0_taken = 1'b1;
    #1;
    n_tests++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_free1_both: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    // Expected after edges: pop 3, 4, 7, 0, then idle; idx 5 never written.
    exp_cnt = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    exp_ld  = 5'b01111;
    exp_pc  = '{3'd3, 3'd4, 3'd7, 3'd0, 3'd0};
    exp_tk  = 5'b01010;
    for (int e = 0; e < 5; e++) begin
      edge_sample();
      if (e == 0) begin
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      n_tests++;
      if (fifo_count !== exp_cnt[e] || ld_bht !== exp_ld[e] ||
          (exp_ld[e] && (pc_taken_in !== exp_pc[e] || taken_in !== exp_tk[e]))) begin
        n_fail++;
        $display("FAIL rr_drain %0d: got cnt=%0d ld=%b idx=%0d tk=%b, want cnt=%0d ld=%b idx=%0d tk=%b",
                 e, fifo_count, ld_bht, pc_taken_in, taken_in,
                 exp_cnt[e], exp_ld[e], exp_pc[e], exp_tk[e]);
      end
    end
  endtask

  task automatic test_flush();
    fill_three(3'd1, 3'd2, 3'd3, 3'd4);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    flush = 1'b1;
    n_tests++;
    if (fifo_count !== 3'd3) begin
      n_fail++;
      $display("FAIL flush_precount: got cnt=%0d want 3", fifo_count);
    end
    edge_sample();
    n_tests++;
    if ({ld_bht, fifo_count, init_busy} !== {1'b0, 3'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL flush_edge: got ld=%b cnt=%0d busy=%b, want 0 0 1",
               ld_bht, fifo_count, init_busy);
    end
    @(negedge clk) flush = 1'b0;
    check_sweep("flush_sweep");
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge clk) flush = 1'b1;
    edge_sample();
    @(negedge clk) flush = 1'b0;
    for (int k = 0; k < 10; k++) edge_sample();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({ld_bht, pc_taken_in, taken_in, init_busy, fifo_count} !== {1'b0, 3'd0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL midreset: got ld=%b idx=%0d tk=%b busy=%b cnt=%0d, want 0 0 0 1 0",
               ld_bht, pc_taken_in, taken_in, init_busy, fifo_count);
    end
    @(negedge clk) rst_n = 1'b1;
    check_sweep("reset_sweep");
  endtask

  initial begin
    test_reset();
    check_sweep("init_sweep");
    test_single();
    test_back_to_back();
    test_ready_rules();
    test_flush();
    test_reset_mid_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
